// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response pair.
// Each transaction takes a fixed, parameterised number of clock edges.
module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT =
      (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
   localparam logic [29:0] DEPTH_W = 30'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_write;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_be;

   logic [31:0] mem [DEPTH];

   logic          in_idle;
   logic          cur_write;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic [3:0]    cur_be;
   logic          cur_err;
   logic [AW-1:0] idx;
   logic          commit;
   logic          wr_en;
   logic [31:0]   rd_next;

   // With LATENCY=1 the commit edge is the accept edge itself,
   // so the live request inputs stand in for the latched copy.
   always_comb begin
      in_idle   = (state == IDLE);
      cur_write = in_idle ? req_write : lat_write;
      cur_addr  = in_idle ? req_addr  : lat_addr;
      cur_wdata = in_idle ? req_wdata : lat_wdata;
      cur_be    = in_idle ? req_be    : lat_be;
      cur_err   = (cur_addr[1:0] != 2'b00) ||
                  (cur_addr[31:2] >= DEPTH_W);
      idx       = cur_addr[AW+1:2];
      commit    = (in_idle && req_valid && req_ready &&
                   (LATENCY == 1)) ||
                  (state == WAIT && cnt == 4'd0);
      wr_en     = commit && !reset && cur_write && !cur_err;
      rd_next   = (cur_write || cur_err) ? 32'd0 : mem[idx];
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_be[b]) begin
               mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_write <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_be    <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_be    <= req_be;
                  req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rd_next;
                     rsp_err   <= cur_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rd_next;
                  rsp_err   <= cur_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'd0;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders at LATENCY 2, 3 and 1,
// directed transactions with hand-computed responses.
module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [2:0]  req_write;
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_be    [3];
   logic [2:0]  rsp_valid;
   logic [2:0]  rsp_ready;
   logic [31:0] rsp_rdata [3];
   logic [2:0]  rsp_err;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int nvec = 0;
   int nmis = 0;

   dmem_responder #(.DEPTH(64), .LATENCY(2)) u0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_responder #(.DEPTH(64), .LATENCY(3)) u1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   dmem_responder #(.DEPTH(64), .LATENCY(1)) u2 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_write(req_write[2]), .req_addr(req_addr[2]),
      .req_wdata(req_wdata[2]), .req_be(req_be[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
      .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int latof(int k);
      return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
   endfunction

   function automatic int qsize(int k);
      return (k == 0) ? q0.size() :
             ((k == 1) ? q1.size() : q2.size());
   endfunction

   task automatic push(int k, logic e, logic [31:0] d);
      exp_t x;
      x.err   = e;
      x.rdata = d;
      case (k)
         0: q0.push_back(x);
         1: q1.push_back(x);
         default: q2.push_back(x);
      endcase
   endtask

   // Monitor: mid-cycle, pop one expectation per response handshake.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rsp_valid[k] === 1'b1 && rsp_ready[k] === 1'b1) begin
            exp_t x;
            if (qsize(k) == 0) begin
               nvec++;
               nmis++;
               $display("FAIL unexpected_rsp dut%0d: got %h err %b",
                        k, rsp_rdata[k], rsp_err[k]);
            end else begin
               case (k)
                  0: x = q0.pop_front();
                  1: x = q1.pop_front();
                  default: x = q2.pop_front();
               endcase
               chk($sformatf("rsp_rdata dut%0d", k), rsp_rdata[k], x.rdata);
               chk($sformatf("rsp_err dut%0d", k),
                   {31'd0, rsp_err[k]}, {31'd0, x.err});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int k, logic v, logic w, logic [31:0] a,
                        logic [31:0] d, logic [3:0] be);
      req_valid[k] = v;
      req_write[k] = w;
      req_addr[k]  = a;
      req_wdata[k] = d;
      req_be[k]    = be;
   endtask

   task automatic wait_rsp(int k, output int n);
      n = 1;
      while (rsp_valid[k] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
   endtask

   task automatic xact(int k, logic w, logic [31:0] a, logic [31:0] d,
                       logic [3:0] be, logic ee, logic [31:0] er);
      int n;
      n = 0;
      while (req_ready[k] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk($sformatf("req_ready_idle dut%0d", k), {31'd0, req_ready[k]}, 1);
      push(k, ee, er);
      drive(k, 1'b1, w, a, d, be);
      step();
      req_valid[k] = 1'b0;
      wait_rsp(k, n);
      chk($sformatf("latency dut%0d", k), n, latof(k));
      step();
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      rsp_ready = 3'b111;
      for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 0, 0, 4'h0);
      repeat (3) step();
      reset = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
         chk("rst_req_ready", {31'd0, req_ready[k]}, 1);
         chk("rst_rsp_valid", {31'd0, rsp_valid[k]}, 0);
         chk("rst_rsp_rdata", rsp_rdata[k], 0);
         chk("rst_rsp_err", {31'd0, rsp_err[k]}, 0);
      end

      // LATENCY=2: round trip, byte enables, errors, boundaries
      xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
      xact(0, 0, 32'h10, 0, 4'h0, 0, 32'hDEADBEEF);
      xact(0, 1, 32'h08, 32'h11223344, 4'hF, 0, 0);
      xact(0, 1, 32'h08, 32'hAABBCCDD, 4'h5, 0, 0);
      xact(0, 0, 32'h08, 0, 4'h0, 0, 32'h11BB33DD);
      xact(0, 1, 32'h00, 32'h01234567, 4'hF, 0, 0);
      xact(0, 0, 32'h102, 0, 4'hF, 1, 0);
      xact(0, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 1, 0);
      xact(0, 1, 32'h01, 32'hFFFFFFFF, 4'hF, 1, 0);
      xact(0, 0, 32'h00, 0, 4'h0, 0, 32'h01234567);
      xact(0, 1, 32'h00, 32'hFFFFFFFF, 4'h0, 0, 0);
      xact(0, 0, 32'h00, 0, 4'h0, 0, 32'h01234567);
      xact(0, 1, 32'hFC, 32'h5A5A5A5A, 4'hF, 0, 0);
      xact(0, 0, 32'hFC, 0, 4'h3, 0, 32'h5A5A5A5A);

      // Backpressure with ignored request pulses
      xact(0, 1, 32'h20, 32'h13579BDF, 4'hF, 0, 0);
      rsp_ready[0] = 1'b0;
      push(0, 0, 32'h13579BDF);
      drive(0, 1'b1, 1'b0, 32'h20, 0, 4'hF);
      step();
      req_valid[0] = 1'b0;
      wait_rsp(0, n);
      chk("bp_latency", n, 2);
      for (int i = 0; i < 5; i++) begin
         drive(0, (i % 2 == 0), 1'b1, 32'h20, 32'h0, 4'hF);
         step();
         chk("bp_rsp_valid", {31'd0, rsp_valid[0]}, 1);
         chk("bp_rsp_rdata", rsp_rdata[0], 32'h13579BDF);
         chk("bp_rsp_err", {31'd0, rsp_err[0]}, 0);
         chk("bp_req_ready", {31'd0, req_ready[0]}, 0);
      end
      drive(0, 1'b0, 1'b0, 0, 0, 4'h0);
      rsp_ready[0] = 1'b1;
      step();
      chk("bp_release_req_ready", {31'd0, req_ready[0]}, 1);
      xact(0, 0, 32'h20, 0, 4'h0, 0, 32'h13579BDF);

      // LATENCY=3: reset in WAIT drops the store
      xact(1, 1, 32'h04, 32'h0BADBEEF, 4'hF, 0, 0);
      drive(1, 1'b1, 1'b1, 32'h04, 32'hCAFEF00D, 4'hF);
      step();
      req_valid[1] = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_wait_rsp_valid", {31'd0, rsp_valid[1]}, 0);
      chk("rst_wait_req_ready", {31'd0, req_ready[1]}, 1);
      repeat (4) step();
      xact(1, 0, 32'h04, 0, 4'h0, 0, 32'h0BADBEEF);

      // Reset coincident with req_valid must not accept
      drive(1, 1'b1, 1'b1, 32'h04, 32'h77777777, 4'hF);
      reset = 1'b1;
      step();
      reset = 1'b0;
      req_valid[1] = 1'b0;
      chk("rst_req_req_ready", {31'd0, req_ready[1]}, 1);
      repeat (4) step();
      xact(1, 0, 32'h04, 0, 4'h0, 0, 32'h0BADBEEF);

      // Reset in RESP keeps the committed store
      rsp_ready[1] = 1'b0;
      drive(1, 1'b1, 1'b1, 32'h0C, 32'h600DF00D, 4'hF);
      step();
      req_valid[1] = 1'b0;
      wait_rsp(1, n);
      chk("resp_rst_latency", n, 3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      rsp_ready[1] = 1'b1;
      chk("rst_resp_rsp_valid", {31'd0, rsp_valid[1]}, 0);
      xact(1, 0, 32'h0C, 0, 4'h0, 0, 32'h600DF00D);

      // LATENCY=1 back-to-back, req_valid and rsp_ready held high
      xact(2, 1, 32'h00, 32'h00000042, 4'hF, 0, 0);
      repeat (4) push(2, 0, 32'h00000042);
      drive(2, 1'b1, 1'b0, 32'h00, 0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("b2b_rsp_valid%0d", i),
             {31'd0, rsp_valid[2]}, (i % 2 == 0) ? 1 : 0);
         chk($sformatf("b2b_req_ready%0d", i),
             {31'd0, req_ready[2]}, (i % 2 == 0) ? 0 : 1);
      end
      req_valid[2] = 1'b0;

      repeat (5) step();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("queue_empty dut%0d", k), qsize(k), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
